branch_resolve_unit: RTL

- Pipelined, parametrised branch/jump resolution unit for the RV core, placed between decode/register-read and the fetch redirect logic.
- Handles conditional branches (all six RV conditions), JAL and JALR, with configurable data width.
- Adds valid/ready handshakes, target alignment checking, illegal-encoding detection and a saturating taken-branch counter.
- Fixed latency of 2 cycles at full throughput; stalls under backpressure.

---
 rtl/branch_resolve_unit_if.sv | 33 +++
 rtl/branch_resolve_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit_if.sv
// Request/result bus between register-read and the branch resolve unit.
// The unit sits on the slave side; the producer/consumer pair is the master.
interface branch_resolve_unit_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      op;
   logic [2:0]      funct3;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] lhs;
   logic [XLEN-1:0] rhs;
   logic [XLEN-1:0] imm;
   logic            out_valid;
   logic            out_ready;
   logic            out_taken;
   logic [XLEN-1:0] out_next_pc;
   logic [XLEN-1:0] out_link;
   logic            out_error;
   logic            out_misaligned;

   modport master (
      output in_valid, op, funct3, pc, lhs, rhs, imm, out_ready,
      input  in_ready, out_valid, out_taken, out_next_pc, out_link,
             out_error, out_misaligned
   );

   modport slave (
      input  in_valid, op, funct3, pc, lhs, rhs, imm, out_ready,
      output in_ready, out_valid, out_taken, out_next_pc, out_link,
             out_error, out_misaligned
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Two-stage branch/jump resolver: stage A captures the request, stage B holds
// the resolved result. Tracks retired, correctly taken transfers.
module branch_resolve_unit #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned ALIGN_BYTES = 4,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   clear,
   branch_resolve_unit_if.slave   bus,
   output logic [COUNT_WIDTH-1:0] taken_count
);
   localparam logic [1:0] OP_BRANCH = 2'd0;
   localparam logic [1:0] OP_JAL    = 2'd1;
   localparam logic [1:0] OP_JALR   = 2'd2;
   localparam logic [1:0] OP_RSVD   = 2'd3;

   typedef struct packed {
      logic [1:0]      op;
      logic [2:0]      funct3;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] lhs;
      logic [XLEN-1:0] rhs;
      logic [XLEN-1:0] imm;
   } req_t;

   typedef struct packed {
      logic            taken;
      logic [XLEN-1:0] next_pc;
      logic [XLEN-1:0] link;
      logic            error;
      logic            misaligned;
   } res_t;

   logic                   a_valid_q, a_valid_d;
   req_t                   a_q, a_d;
   logic                   b_valid_q, b_valid_d;
   res_t                   b_q, b_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;

   res_t            res;
   logic [XLEN-1:0] pc4, target, jalr_sum, lhs_x, rhs_x;
   logic            cond, is_jump, err, taken, b_free, a_adv;

   // Resolve the request held in stage A.
   always_comb begin
      pc4      = a_q.pc + XLEN'(4);
      jalr_sum = a_q.lhs + a_q.imm;
      lhs_x    = {~a_q.lhs[XLEN-1], a_q.lhs[XLEN-2:0]};
      rhs_x    = {~a_q.rhs[XLEN-1], a_q.rhs[XLEN-2:0]};
      target   = (a_q.op == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : a_q.pc + a_q.imm;
      is_jump  = (a_q.op == OP_JAL) || (a_q.op == OP_JALR);

      cond = 1'b0;
      unique case (a_q.funct3)
         3'd0:    cond = (a_q.lhs == a_q.rhs);
         3'd1:    cond = (a_q.lhs != a_q.rhs);
         3'd4:    cond = (lhs_x < rhs_x);
         3'd5:    cond = (lhs_x >= rhs_x);
         3'd6:    cond = (a_q.lhs < a_q.rhs);
         3'd7:    cond = (a_q.lhs >= a_q.rhs);
         default: cond = 1'b0;
      endcase

      err = (a_q.op == OP_RSVD)
         || ((a_q.op == OP_BRANCH) && (a_q.funct3[2:1] == 2'b01))
         || ((a_q.op == OP_JALR) && (a_q.funct3 != 3'd0));
      taken = !err && (is_jump || ((a_q.op == OP_BRANCH) && cond));

      res.taken   = taken;
      res.error   = err;
      res.next_pc = taken ? target : pc4;
      res.link    = (!err && is_jump) ? pc4 : '0;
      if (ALIGN_BYTES == 2) res.misaligned = taken && target[0];
      else                  res.misaligned = taken && (|target[1:0]);
   end

   // Pipeline advance and next-state.
   always_comb begin
      b_free    = !b_valid_q || bus.out_ready;
      a_adv     = a_valid_q && b_free;
      a_valid_d = a_valid_q;
      a_d       = a_q;
      b_valid_d = b_valid_q;
      b_d       = b_q;
      count_d   = count_q;

      if (!a_valid_q || a_adv) begin
         a_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            a_d.op     = bus.op;
            a_d.funct3 = bus.funct3;
            a_d.pc     = bus.pc;
            a_d.lhs    = bus.lhs;
            a_d.rhs    = bus.rhs;
            a_d.imm    = bus.imm;
         end
      end

      if (b_free) begin
         b_valid_d = a_valid_q;
         if (a_valid_q) b_d = res;
      end

      if (b_valid_q && bus.out_ready && b_q.taken && !b_q.error && !b_q.misaligned
          && (count_q != '1))
         count_d = count_q + COUNT_WIDTH'(1);
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         a_valid_q <= 1'b0;
         a_q       <= '0;
         b_valid_q <= 1'b0;
         b_q       <= '0;
         count_q   <= '0;
      end else begin
         a_valid_q <= a_valid_d;
         a_q       <= a_d;
         b_valid_q <= b_valid_d;
         b_q       <= b_d;
         count_q   <= count_d;
      end
   end

   assign bus.in_ready       = !a_valid_q || a_adv;
   assign bus.out_valid      = b_valid_q;
   assign bus.out_taken      = b_q.taken;
   assign bus.out_next_pc    = b_q.next_pc;
   assign bus.out_link       = b_q.link;
   assign bus.out_error      = b_q.error;
   assign bus.out_misaligned = b_q.misaligned;
   assign taken_count        = count_q;
endmodule
